// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: instruction fetch sequencer for the Jolt160 core.
// Fetches 16-bit halfwords over a req/ack memory port and classifies the
// first halfword into groups 1-5. Only group 5 fetches a trailing
// immediate halfword. The assembled instruction goes to decode over a
// valid/ready handshake. The sequencer owns the PC and takes branch redirects.
// Optional feature macro: JOLT160_ILLEGAL_TRAP_EN. When it is defined, an
// unknown encoding raises illegal_instr and halts fetch until reset.
module instr_fetch_seq #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        redir_valid,
  input  logic [15:0] redir_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_instr_hi,
  output logic [15:0] dec_instr_lo,
  output logic [2:0]  dec_group,
  output logic [15:0] dec_pc,
  output logic        illegal_instr
);

`ifdef JOLT160_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_HI = 3'd1,
    REQ_LO = 3'd2,
    OUT    = 3'd3,
    DRAIN  = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic        mem_req_next;
  logic [15:0] mem_addr_next;
  logic        dec_valid_next;
  logic [15:0] instr_hi_next, instr_lo_next;
  logic [2:0]  group_next;
  logic [15:0] dec_pc_next;
  logic        illegal_next;
  logic [2:0]  rdata_group;

  // Priority decode of the first halfword into its instruction group.
  function automatic logic [2:0] classify(input logic [15:0] h);
    logic [2:0] g;
    if (h[15] == 1'b0)                g = 3'd1;
    else if (h[15:14] == 2'b10)       g = 3'd2;
    else if (h[15:12] == 4'b1100)     g = 3'd3;
    else if (h[15:12] == 4'b1101)     g = 3'd4;
    else if (h[15:10] == 6'b111000)   g = 3'd5;
    else                              g = 3'd0;
    return g;
  endfunction

  // Group of the halfword currently on the read bus.
  always_comb begin
    rdata_group = classify(mem_rdata);
  end

  // Next-state and next-output logic. A redirect overrides the per-state result.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    mem_req_next   = mem_req;
    mem_addr_next  = mem_addr;
    dec_valid_next = dec_valid;
    instr_hi_next  = dec_instr_hi;
    instr_lo_next  = dec_instr_lo;
    group_next     = dec_group;
    dec_pc_next    = dec_pc;
    illegal_next   = illegal_instr;

    case (state_reg)
      IDLE: begin
        pc_next        = RESET_PC;
        state_next     = REQ_HI;
        mem_req_next   = 1'b1;
        mem_addr_next  = RESET_PC;
        dec_valid_next = 1'b0;
      end
      REQ_HI: begin
        if (mem_ack) begin
          instr_hi_next = mem_rdata;
          group_next    = rdata_group;
          dec_pc_next   = pc_reg;
          pc_next       = pc_reg + 16'd1;
          if (rdata_group == 3'd5) begin
            // Request stays high and moves on to the immediate halfword.
            state_next    = REQ_LO;
            mem_addr_next = pc_reg + 16'd1;
          end else begin
            instr_lo_next  = 16'h0000;
            state_next     = OUT;
            mem_req_next   = 1'b0;
            dec_valid_next = 1'b1;
            illegal_next   = TRAP_EN && (rdata_group == 3'd0);
          end
        end
      end
      REQ_LO: begin
        if (mem_ack) begin
          instr_lo_next  = mem_rdata;
          pc_next        = pc_reg + 16'd1;
          state_next     = OUT;
          mem_req_next   = 1'b0;
          dec_valid_next = 1'b1;
        end
      end
      OUT: begin
        if (dec_ready) begin
          dec_valid_next = 1'b0;
          if (TRAP_EN && illegal_instr) begin
            // The trapped encoding has been handed over; fetch stops here.
            state_next = HALT;
          end else begin
            state_next    = REQ_HI;
            mem_req_next  = 1'b1;
            mem_addr_next = pc_reg;
          end
        end
      end
      DRAIN: begin
        // The stale read completes and its data is dropped. Then fetch restarts at the redirect target.
        if (mem_ack) begin
          state_next    = REQ_HI;
          mem_addr_next = pc_reg;
        end
      end
      HALT: begin
        mem_req_next   = 1'b0;
        dec_valid_next = 1'b0;
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase

    if (redir_valid && (state_reg != HALT)) begin
      pc_next        = redir_pc;
      dec_valid_next = 1'b0;
      illegal_next   = 1'b0;
      mem_req_next   = 1'b1;
      if (mem_req && !mem_ack) begin
        // A read is outstanding and cannot be withdrawn. Hold its address until it is acked.
        state_next    = DRAIN;
        mem_addr_next = mem_addr;
      end else begin
        state_next    = REQ_HI;
        mem_addr_next = redir_pc;
      end
    end
  end

  // State, PC and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      mem_req       <= 1'b0;
      mem_addr      <= RESET_PC;
      dec_valid     <= 1'b0;
      dec_instr_hi  <= 16'h0000;
      dec_instr_lo  <= 16'h0000;
      dec_group     <= 3'd0;
      dec_pc        <= RESET_PC;
      illegal_instr <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      mem_req       <= mem_req_next;
      mem_addr      <= mem_addr_next;
      dec_valid     <= dec_valid_next;
      dec_instr_hi  <= instr_hi_next;
      dec_instr_lo  <= instr_lo_next;
      dec_group     <= group_next;
      dec_pc        <= dec_pc_next;
      illegal_instr <= illegal_next;
    end
  end

endmodule
